pll_reconfig_ctl: RTL
=====================

PLL_RECONFIG_CTL -- requirements
Module: pll_reconfig_ctl

Interface
REQ-001 Parameter LOCK_TMO, default 16'd50000: hb_clk cycles to wait for PLL lock before flagging an error.
REQ-002 Parameter WBUSY_TMO, default 8'd255: hb_clk cycles to wait for busy to drop after each write or reconfig.
REQ-003 hb_clk  in  1  system clock; all logic on rising edge.
REQ-004 hb_reset  in  1  asynchronous, active-high reset.
REQ-005 pixreg20..pixreg27  in  8 each  four frequency words, word k = {pixreg(21+2k), pixreg(20+2k)}.
REQ-006 int_fs  in  2  selects frequency word k.
REQ-007 busy  in  1  PLL reconfig engine busy.
REQ-008 pll_locked  in  1  PLL lock, asynchronous to hb_clk.
REQ-009 counter_type  out  4  target counter: 0000 = N, 0001 = M.
REQ-010 counter_param  out  3  field: 000 high, 001 low, 100 bypass, 101 odd.
REQ-011 data_in  out  9  field value.
REQ-012 write_param  out  1  one-cycle write strobe.
REQ-013 reconfig  out  1  one-cycle apply strobe.
REQ-014 pix_locked  out  1  reconfiguration complete and PLL locked.
REQ-015 reconf_err  out  1  sticky error flag; cleared by the next successful sequence.

Function
REQ-016 Word decode: M = word[7:0] + 1 (range 1..256); N = word[12:8] + 1 (range 1..32); bits 15:13 are ignored.
REQ-017 Counter split for count K: if K==1, bypass=1, high=1, low=1, odd=0; otherwise bypass=0, high=ceil(K/2), low=floor(K/2), odd=K[0]; all fields are 9-bit.
REQ-018 pll_locked passes through a 2-flop synchronizer before use.
REQ-019 A sequence starts when the selected word differs from the last programmed word, or when int_fs changes; the first sequence after reset always runs.
REQ-020 FSM states: IDLE, LOAD, WRITE, WAIT_W, RECFG, WAIT_R, WAIT_LOCK.
REQ-021 IDLE -> LOAD on a start condition; LOAD snapshots the word and drops pix_locked in the same cycle.
REQ-022 Write order is N high, N low, N bypass, N odd, then M high, M low, M bypass, M odd (8 writes).
REQ-023 WRITE drives counter_type, counter_param and data_in and pulses write_param for one cycle; outputs hold stable until WAIT_W exits.
REQ-024 WAIT_W waits for busy==0, sampled no earlier than 2 cycles after the strobe; it then advances to the next write, or to RECFG after the 8th write.
REQ-025 RECFG pulses reconfig for one cycle -> WAIT_R, which waits for busy==0 (same 2-cycle rule) -> WAIT_LOCK.
REQ-026 WAIT_LOCK: when synchronized lock==1, set pix_locked=1, clear reconf_err, record the programmed word, and go to IDLE.
REQ-027 A busy timeout (WBUSY_TMO) or lock timeout (LOCK_TMO) sets reconf_err, leaves pix_locked=0, and goes to IDLE; no retry until the next start condition.
REQ-028 A word or int_fs change during a sequence sets a pending flag; on return to IDLE the next sequence starts immediately. Multiple changes collapse into one sequence using the latest value.
REQ-029 Loss of synchronized lock while in IDLE clears pix_locked within 3 cycles; no reprogramming is triggered.
REQ-030 write_param and reconfig are never asserted in the same cycle, and neither asserts while busy==1.

Reset
REQ-031 Reset forces the FSM to IDLE and sets all outputs to 0; the last-programmed word becomes invalid, so a sequence starts on the first cycle after release.
REQ-032 Reset asserted mid-sequence aborts immediately; no further strobes issue.

Structure
REQ-033 A shared package holds the state enum, the counter_type and counter_param codes, and the count-split function.
REQ-034 One sub-module, pll_cnt_split (K -> high/low/bypass/odd), is instantiated twice, once for N and once for M.

Verification
REQ-035 Reset release with int_fs=0 and word 0x1015 -> writes N: h=9, l=8, b=0, o=1; M: h=11, l=11, b=0, o=0; then reconfig; pix_locked=1 after lock.
REQ-036 Word 0x0000 -> N and M both written with bypass=1; exactly 8 write_param pulses and 1 reconfig pulse.
REQ-037 int_fs changed 0 -> 1 mid-WRITE -> first sequence completes, a second starts with word 1, and pix_locked stays 0 between the two.
REQ-038 busy held at 1 after the 3rd write -> reconf_err=1 after 255 cycles, FSM returns to IDLE, no reconfig pulse; a later word change reruns the sequence and clears reconf_err.
REQ-039 pll_locked never asserts -> reconf_err=1 after LOCK_TMO cycles and pix_locked=0.
REQ-040 hb_reset asserted during WAIT_R -> outputs go to 0 asynchronously, and a full sequence reruns after release.

Source files
------------

// File: rtl/pll_reconfig_ctl_pkg.sv
// rtl/pll_reconfig_ctl_pkg.sv - shared types, counter codes and the count-split helper
package pll_reconfig_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_WAIT_W,
    ST_RECFG,
    ST_WAIT_R,
    ST_WAIT_LOCK
  } state_e;

  localparam logic [3:0] CT_N = 4'b0000;
  localparam logic [3:0] CT_M = 4'b0001;

  localparam logic [2:0] CP_HIGH   = 3'b000;
  localparam logic [2:0] CP_LOW    = 3'b001;
  localparam logic [2:0] CP_BYPASS = 3'b100;
  localparam logic [2:0] CP_ODD    = 3'b101;

  localparam logic [2:0] LAST_WRITE_IDX = 3'd7;

  typedef struct packed {
    logic [8:0] high;
    logic [8:0] low;
    logic [8:0] bypass;
    logic [8:0] odd;
  } cnt_split_t;

  // A divide-by-one counter is expressed as bypass; otherwise the odd bit lets
  // the high phase carry the extra cycle.
  function automatic cnt_split_t cnt_split(input logic [8:0] k);
    cnt_split_t s;
    if (k == 9'd1) begin
      s.high   = 9'd1;
      s.low    = 9'd1;
      s.bypass = 9'd1;
      s.odd    = 9'd0;
    end else begin
      s.high   = (k >> 1) + {8'd0, k[0]};
      s.low    = k >> 1;
      s.bypass = 9'd0;
      s.odd    = {8'd0, k[0]};
    end
    return s;
  endfunction

endpackage

// File: rtl/pll_reconfig_ctl_cnt_split.sv
// rtl/pll_reconfig_ctl_cnt_split.sv - splits a divider count into high/low/bypass/odd fields
module pll_cnt_split
  import pll_reconfig_ctl_pkg::*;
(
  input  logic [8:0] k_i,
  output logic [8:0] high_o,
  output logic [8:0] low_o,
  output logic [8:0] bypass_o,
  output logic [8:0] odd_o
);

  cnt_split_t split;

  always_comb split = cnt_split(k_i);

  assign high_o   = split.high;
  assign low_o    = split.low;
  assign bypass_o = split.bypass;
  assign odd_o    = split.odd;

endmodule

// File: rtl/pll_reconfig_ctl.sv
// rtl/pll_reconfig_ctl.sv - programs PLL N/M counters from the selected frequency word
module pll_reconfig_ctl
  import pll_reconfig_ctl_pkg::*;
#(
  parameter logic [15:0] LOCK_TMO  = 16'd50000,
  parameter logic [7:0]  WBUSY_TMO = 8'd255
) (
  input  logic       hb_clk,
  input  logic       hb_reset,
  input  logic [7:0] pixreg20,
  input  logic [7:0] pixreg21,
  input  logic [7:0] pixreg22,
  input  logic [7:0] pixreg23,
  input  logic [7:0] pixreg24,
  input  logic [7:0] pixreg25,
  input  logic [7:0] pixreg26,
  input  logic [7:0] pixreg27,
  input  logic [1:0] int_fs,
  input  logic       busy,
  input  logic       pll_locked,
  output logic [3:0] counter_type,
  output logic [2:0] counter_param,
  output logic [8:0] data_in,
  output logic       write_param,
  output logic       reconfig,
  output logic       pix_locked,
  output logic       reconf_err
);

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [1:0]  fs_q, fs_d;
  logic        ref_valid_q, ref_valid_d;
  logic        pending_q, pending_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pix_locked_q, pix_locked_d;
  logic        reconf_err_q, reconf_err_d;
  logic        lock_meta_q, lock_sync_q;

  logic [15:0] sel_word;
  logic        changed, busy_ok, busy_tmo, in_write;
  logic [8:0]  n_k, m_k;
  logic [8:0]  n_high, n_low, n_bypass, n_odd;
  logic [8:0]  m_high, m_low, m_bypass, m_odd;
  logic [3:0]  fld_type;
  logic [2:0]  fld_param;
  logic [8:0]  fld_data;

  always_comb begin
    sel_word = {pixreg21, pixreg20};
    case (int_fs)
      2'd1:    sel_word = {pixreg23, pixreg22};
      2'd2:    sel_word = {pixreg25, pixreg24};
      2'd3:    sel_word = {pixreg27, pixreg26};
      default: sel_word = {pixreg21, pixreg20};
    endcase
  end

  // Compared against the snapshot of the last attempted sequence, so a failed
  // sequence is not retried until the inputs actually move.
  assign changed = !ref_valid_q || (sel_word != word_q) || (int_fs != fs_q);

  assign n_k = {4'd0, word_q[12:8]} + 9'd1;
  assign m_k = {1'b0, word_q[7:0]} + 9'd1;

  pll_cnt_split u_split_n (
    .k_i      (n_k),
    .high_o   (n_high),
    .low_o    (n_low),
    .bypass_o (n_bypass),
    .odd_o    (n_odd)
  );

  pll_cnt_split u_split_m (
    .k_i      (m_k),
    .high_o   (m_high),
    .low_o    (m_low),
    .bypass_o (m_bypass),
    .odd_o    (m_odd)
  );

  assign fld_type = idx_q[2] ? CT_M : CT_N;

  always_comb begin
    fld_param = CP_HIGH;
    fld_data  = '0;
    case (idx_q[1:0])
      2'd0: begin
        fld_param = CP_HIGH;
        fld_data  = idx_q[2] ? m_high : n_high;
      end
      2'd1: begin
        fld_param = CP_LOW;
        fld_data  = idx_q[2] ? m_low : n_low;
      end
      2'd2: begin
        fld_param = CP_BYPASS;
        fld_data  = idx_q[2] ? m_bypass : n_bypass;
      end
      default: begin
        fld_param = CP_ODD;
        fld_data  = idx_q[2] ? m_odd : n_odd;
      end
    endcase
  end

  assign in_write      = (state_q == ST_WRITE) || (state_q == ST_WAIT_W);
  assign counter_type  = in_write ? fld_type  : 4'd0;
  assign counter_param = in_write ? fld_param : 3'd0;
  assign data_in       = in_write ? fld_data  : 9'd0;
  assign write_param   = (state_q == ST_WRITE) && !busy;
  assign reconfig      = (state_q == ST_RECFG) && !busy;
  assign pix_locked    = pix_locked_q;
  assign reconf_err    = reconf_err_q;

  // cnt_q counts cycles since the strobe; busy is ignored in the first wait cycle.
  assign busy_ok  = (cnt_q != 16'd0) && !busy;
  assign busy_tmo = cnt_q >= {8'd0, WBUSY_TMO};

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    fs_d         = fs_q;
    ref_valid_d  = ref_valid_q;
    pending_d    = pending_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pix_locked_d = pix_locked_q;
    reconf_err_d = reconf_err_q;

    if (state_q != ST_IDLE && changed) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!lock_sync_q) pix_locked_d = 1'b0;
        if (changed || pending_q) begin
          word_d       = sel_word;
          fs_d         = int_fs;
          ref_valid_d  = 1'b1;
          pending_d    = 1'b0;
          pix_locked_d = 1'b0;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        idx_d   = 3'd0;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (!busy) begin
          cnt_d   = 16'd0;
          state_d = ST_WAIT_W;
        end
      end
      ST_WAIT_W: begin
        cnt_d = cnt_q + 16'd1;
        if (busy_ok) begin
          if (idx_q == LAST_WRITE_IDX) begin
            state_d = ST_RECFG;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_WRITE;
          end
        end else if (busy_tmo) begin
          reconf_err_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_RECFG: begin
        if (!busy) begin
          cnt_d   = 16'd0;
          state_d = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        cnt_d = cnt_q + 16'd1;
        if (busy_ok) begin
          cnt_d   = 16'd0;
          state_d = ST_WAIT_LOCK;
        end else if (busy_tmo) begin
          reconf_err_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_WAIT_LOCK: begin
        cnt_d = cnt_q + 16'd1;
        if (lock_sync_q) begin
          // A queued change keeps pix_locked low across the back-to-back rerun.
          pix_locked_d = !(pending_q || changed);
          reconf_err_d = 1'b0;
          state_d      = ST_IDLE;
        end else if (cnt_q >= LOCK_TMO) begin
          reconf_err_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hb_clk or posedge hb_reset) begin
    if (hb_reset) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      fs_q         <= '0;
      ref_valid_q  <= 1'b0;
      pending_q    <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      pix_locked_q <= 1'b0;
      reconf_err_q <= 1'b0;
      lock_meta_q  <= 1'b0;
      lock_sync_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      fs_q         <= fs_d;
      ref_valid_q  <= ref_valid_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pix_locked_q <= pix_locked_d;
      reconf_err_q <= reconf_err_d;
      lock_meta_q  <= pll_locked;
      lock_sync_q  <= lock_meta_q;
    end
  end

endmodule
